block_checker: RTL and testbench

BLOCK_CHECKER -- requirements
Module: block_checker

---
 rtl/block_checker_pkg.sv | 34 +++
 rtl/block_checker.sv | 95 +++++++++
 tb/tb_block_checker.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/block_checker_pkg.sv
// Shared definitions for the begin/end keyword balance checker:
// word-recognition states, ASCII constants and case folding.
package block_checker_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_B     = 4'd1,
        ST_BE    = 4'd2,
        ST_BEG   = 4'd3,
        ST_BEGI  = 4'd4,
        ST_BEGIN = 4'd5,
        ST_E     = 4'd6,
        ST_EN    = 4'd7,
        ST_END   = 4'd8,
        ST_OTHER = 4'd9
    } state_e;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_B     = 8'h62;
    localparam logic [7:0] CH_E     = 8'h65;
    localparam logic [7:0] CH_G     = 8'h67;
    localparam logic [7:0] CH_I     = 8'h69;
    localparam logic [7:0] CH_N     = 8'h6E;
    localparam logic [7:0] CH_D     = 8'h64;

    // Upper-case letters map to lower case; all other bytes pass through unchanged.
    function automatic logic [7:0] fold_case(input logic [7:0] c);
        if (c >= 8'h41 && c <= 8'h5A) begin
            return c | 8'h20;
        end
        return c;
    endfunction

endpackage

// File: rtl/block_checker.sv
// Streams one ASCII character per clock and reports whether the begin/end
// keywords seen so far are balanced with no unmatched end.
module block_checker
    import block_checker_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in,
    output logic             result,
    output logic [3:0]       st,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fail_q, fail_d;
    logic [7:0]       ch;
    logic             is_space;

    assign ch       = fold_case(in);
    assign is_space = (in == CH_SPACE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
        end
    end

    // The counter moves tentatively on keyword completion and is undone
    // if the word turns out to continue past the keyword.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        if (is_space) begin
            state_d = ST_IDLE;
            if (state_q == ST_END && cnt_q[CNT_W-1]) begin
                fail_d = 1'b1;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ch == CH_B)      state_d = ST_B;
                    else if (ch == CH_E) state_d = ST_E;
                    else                 state_d = ST_OTHER;
                end
                ST_B:    state_d = (ch == CH_E) ? ST_BE   : ST_OTHER;
                ST_BE:   state_d = (ch == CH_G) ? ST_BEG  : ST_OTHER;
                ST_BEG:  state_d = (ch == CH_I) ? ST_BEGI : ST_OTHER;
                ST_BEGI: begin
                    if (ch == CH_N) begin
                        state_d = ST_BEGIN;
                        cnt_d   = cnt_q + ONE;
                    end else begin
                        state_d = ST_OTHER;
                    end
                end
                ST_BEGIN: begin
                    state_d = ST_OTHER;
                    cnt_d   = cnt_q - ONE;
                end
                ST_E:    state_d = (ch == CH_N) ? ST_EN : ST_OTHER;
                ST_EN: begin
                    if (ch == CH_D) begin
                        state_d = ST_END;
                        cnt_d   = cnt_q - ONE;
                    end else begin
                        state_d = ST_OTHER;
                    end
                end
                ST_END: begin
                    state_d = ST_OTHER;
                    cnt_d   = cnt_q + ONE;
                end
                ST_OTHER: state_d = ST_OTHER;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    assign result = !fail_q && (cnt_q == '0);
    assign st     = state_q;
    assign cnt    = cnt_q;

endmodule

// File: tb/tb_block_checker.sv
// Scoreboard bench for block_checker: stimulus queues expected outputs,
// a negedge monitor pops and compares them once they fall due.
module tb_block_checker;

    logic        clk;
    logic        reset;
    logic [7:0]  in;
    logic        result;
    logic [3:0]  st;
    logic [31:0] cnt;

    block_checker #(.CNT_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in),
        .result (result),
        .st     (st),
        .cnt    (cnt)
    );

    typedef struct {
        int          due;
        logic [3:0]  st;
        logic [31:0] cnt;
        logic        res;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            n_total++;
            if (st === e.st && cnt === e.cnt && result === e.res) begin
                n_pass++;
            end else begin
                $display("FAIL %s: got st=%0d cnt=%h result=%b, expected st=%0d cnt=%h result=%b",
                         e.name, st, cnt, result, e.st, e.cnt, e.res);
            end
        end
    end

    // Expectation for the outputs after the next rising edge.
    task automatic expect_next(input logic [3:0] s, input logic [31:0] c,
                               input logic r, input string name);
        exp_t e;
        e.due = cyc + 1; e.st = s; e.cnt = c; e.res = r; e.name = name;
        q.push_back(e);
    endtask

    // Expectation for the outputs as they stand now (checked at the next negedge).
    task automatic expect_now(input logic [3:0] s, input logic [31:0] c,
                              input logic r, input string name);
        exp_t e;
        e.due = cyc; e.st = s; e.cnt = c; e.res = r; e.name = name;
        q.push_back(e);
    endtask

    task automatic send(input logic [7:0] c);
        @(negedge clk);
        in = c;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        in    = 8'h20;
        reset = 1'b0;
        #1;
        expect_now(4'd0, 32'd0, 1'b1, name);
        @(negedge clk);
        reset = 1'b1;
    endtask

    localparam logic [31:0] M1 = 32'hFFFF_FFFF;

    initial begin
        reset = 1'b0;
        in    = 8'h20;
        #12;
        expect_now(4'd0, 32'd0, 1'b1, "reset_state");
        @(negedge clk);
        reset = 1'b1;
        send_str("  ");     expect_next(0, 0, 1, "idle_after_release");

        send_str("begin");  expect_next(5, 1, 0, "begin_open");
        send_str(" end");   expect_next(8, 0, 1, "end_close");
        send_str(" ");      expect_next(0, 0, 1, "space_idle");

        send_str("BeGiN");  expect_next(5, 1, 0, "mixed_begin");
        send_str("  ");     expect_next(0, 1, 0, "double_space");
        send_str("eNd");    expect_next(8, 0, 1, "mixed_end");
        send_str(" ");      expect_next(0, 0, 1, "mixed_space");

        send_str("begin");  expect_next(5, 1, 0, "beginx_n");
        send_str("x");      expect_next(9, 0, 1, "beginx_x");
        send_str(" end");   expect_next(8, M1, 0, "endd_end");
        send_str("d");      expect_next(9, 0, 1, "endd_d");
        send_str(" ");      expect_next(0, 0, 1, "endd_space");

        send_str("b3gin");  expect_next(9, 0, 1, "nonletter");
        send_str(" ");      expect_next(0, 0, 1, "nonletter_space");

        send_str("begin begin"); expect_next(5, 2, 0, "nested_two");
        send_str(" end end");    expect_next(8, 0, 1, "nested_closed");
        send_str(" end");        expect_next(8, M1, 0, "stray_end");
        send_str(" ");           expect_next(0, M1, 0, "stray_fail");

        do_reset("reset_clears_fail");
        send_str("end");    expect_next(8, M1, 0, "seq_end");
        send_str(" ");      expect_next(0, M1, 0, "seq_fail");
        send_str("begin");  expect_next(5, 0, 0, "seq_begin_failed");
        send_str(" endd");  expect_next(9, 0, 0, "seq_endd");
        send_str(" word");  expect_next(9, 0, 0, "seq_word");

        do_reset("seq_reset");

        send_str("begi");   expect_next(4, 0, 1, "mid_begi");
        send("n");
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        expect_now(0, 0, 1, "async_reset");
        @(negedge clk);
        in = 8'h20;
        @(negedge clk);
        reset = 1'b1;
        send_str("end");    expect_next(8, M1, 0, "after_reset_end");
        do_reset("end_then_reset");

        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            n_total++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
